// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box tables, GF(2^8) helpers, Rcon and the engine state type.
// Used by both the encryption and decryption engines.
package aes_pkg;

    localparam int unsigned AES_NR   = 10;
    localparam logic [3:0]  RND_LAST = 4'(AES_NR);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} aes_state_t;

    // 16 bytes of one block, byte 0 at index 15 so that blk_t'(x) keeps [127:120] as byte 0
    typedef logic [15:0][7:0] blk_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry x sits at bit offset (255-x)*8, i.e. {~x, 3'b000}
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return INV_SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Round key i from round key i-1
    function automatic logic [127:0] key_expand_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = prev;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_decrypt_engine_if.sv
// Request/response bundle of the AES decryption engine.
interface aes_decrypt_engine_if;
    logic [127:0] anahtar;
    logic [127:0] blok;
    logic         g_gecerli;
    logic         hazir;
    logic [127:0] duz_metin;
    logic         c_gecerli;

    modport master (output anahtar, output blok, output g_gecerli,
                    input  hazir, input duz_metin, input c_gecerli);
    modport slave  (input  anahtar, input blok, input g_gecerli,
                    output hazir, output duz_metin, output c_gecerli);
endinterface

// File: rtl/aes_inv_round.sv
// One AES inverse round (combinational): InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// last=1 skips InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    blk_t s_in, sh, sb, ky, mx;

    always_comb begin
        s_in = state;
        sh   = '0;
        sb   = '0;
        mx   = '0;
        // byte (row r, column c) is byte index 4c+r, stored at s_in[15-(4c+r)]
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sh[15 - (4*c + r)] = s_in[15 - (4*((c + 4 - r) % 4) + r)];
            end
        end
        for (int unsigned i = 0; i < 16; i++) begin
            sb[i] = inv_sbox(sh[i]);
        end
        ky = sb ^ rk;
        for (int unsigned c = 0; c < 4; c++) begin
            mx[15 - 4*c] = gmul(ky[15 - 4*c], 8'h0e) ^ gmul(ky[14 - 4*c], 8'h0b)
                         ^ gmul(ky[13 - 4*c], 8'h0d) ^ gmul(ky[12 - 4*c], 8'h09);
            mx[14 - 4*c] = gmul(ky[15 - 4*c], 8'h09) ^ gmul(ky[14 - 4*c], 8'h0e)
                         ^ gmul(ky[13 - 4*c], 8'h0b) ^ gmul(ky[12 - 4*c], 8'h0d);
            mx[13 - 4*c] = gmul(ky[15 - 4*c], 8'h0d) ^ gmul(ky[14 - 4*c], 8'h09)
                         ^ gmul(ky[13 - 4*c], 8'h0e) ^ gmul(ky[12 - 4*c], 8'h0b);
            mx[12 - 4*c] = gmul(ky[15 - 4*c], 8'h0b) ^ gmul(ky[14 - 4*c], 8'h0d)
                         ^ gmul(ky[13 - 4*c], 8'h09) ^ gmul(ky[12 - 4*c], 8'h0e);
        end
        state_out = last ? ky : mx;
    end

endmodule

// File: rtl/aes_decrypt_engine.sv
// Iterative AES-128 decryption engine: 10-cycle key expansion (skippable on a cached key),
// then one inverse round per clock; plaintext returned with a one-cycle c_gecerli pulse.
module aes_decrypt_engine
    import aes_pkg::*;
#(
    parameter int unsigned KEY_CACHE = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    aes_decrypt_engine_if.slave  bus
);

    aes_state_t                 state_q, state_d;
    logic [3:0]                 ctr_q;
    logic [AES_NR:0][127:0]     rk_q;
    logic [127:0]               st_q;
    logic [127:0]               duz_q;
    logic                       c_gecerli_q;
    logic                       cache_valid_q;

    logic                       hazir;
    logic                       accept;
    logic                       cache_hit;
    logic                       last;
    logic [127:0]               rk_sel;
    logic [127:0]               round_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = cache_hit ? INIT : KEYEXP;
            KEYEXP:  if (ctr_q == RND_LAST) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (ctr_q == 4'd1) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The cached key is rk_q[0]: it only changes on a miss accept, which always runs KEYEXP
    always_comb begin
        hazir     = (state_q == IDLE);
        accept    = hazir && bus.g_gecerli;
        cache_hit = (KEY_CACHE != 0) && cache_valid_q && (bus.anahtar == rk_q[0]);
        last      = (state_q == FINAL);
        rk_sel    = rk_q[ctr_q];
    end

    aes_inv_round u_inv_round (
        .state     (st_q),
        .rk        (rk_sel),
        .last      (last),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q         <= '0;
            rk_q          <= '0;
            st_q          <= '0;
            duz_q         <= '0;
            c_gecerli_q   <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            c_gecerli_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        st_q    <= bus.blok;
                        rk_q[0] <= bus.anahtar;
                        ctr_q   <= cache_hit ? 4'd0 : 4'd1;
                    end
                end
                KEYEXP: begin
                    rk_q[ctr_q] <= key_expand_step(rk_q[ctr_q - 4'd1], rcon(ctr_q));
                    if (ctr_q == RND_LAST) cache_valid_q <= 1'b1;
                    else                   ctr_q         <= ctr_q + 4'd1;
                end
                INIT: begin
                    st_q  <= st_q ^ rk_q[AES_NR];
                    ctr_q <= 4'd9;
                end
                ROUND: begin
                    st_q  <= round_out;
                    ctr_q <= ctr_q - 4'd1;
                end
                FINAL: begin
                    duz_q       <= round_out;
                    c_gecerli_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.hazir     = hazir;
    assign bus.duz_metin = duz_q;
    assign bus.c_gecerli = c_gecerli_q;

endmodule

// File: tb/tb_aes_decrypt_engine.sv
// Self-checking bench for aes_decrypt_engine: FIPS-197 vectors, key cache, busy inputs,
// mid-operation reset and a randomized loopback through a behavioural AES-128 encryptor.
module tb_aes_decrypt_engine;

    localparam int unsigned KC = 1;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst;

    aes_decrypt_engine_if bus ();

    aes_decrypt_engine #(.KEY_CACHE(KC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int done_blocks = 0;

    logic [7:0]   tb_sbox [256];
    bit           m_cache_valid = 1'b0;
    logic [127:0] m_cache_key   = '0;

    always @(negedge clk) if (bus.c_gecerli === 1'b1) pulses++;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // GF(2^8) product by polynomial multiply then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (p[k]) p ^= (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gf(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   a0, a1, a2, a3, rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = key[127 - 8*i -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp[0] = tb_sbox[w[4*i - 3]] ^ rc;
                tmp[1] = tb_sbox[w[4*i - 2]];
                tmp[2] = tb_sbox[w[4*i - 1]];
                tmp[3] = tb_sbox[w[4*i - 4]];
                rc = gf(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gf(a0, 8'h02) ^ gf(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gf(a1, 8'h02) ^ gf(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gf(a2, 8'h02) ^ gf(a3, 8'h03);
                    s[4*c+3] = gf(a0, 8'h03) ^ a1 ^ a2 ^ gf(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*rnd + i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents one block while the engine is idle, waits for the pulse and checks result and latency.
    task automatic do_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                            input logic [127:0] exp_pt, input bit noise);
        int lat;
        int exp_lat;
        bit seen;
        exp_lat = (KC != 0 && m_cache_valid && key == m_cache_key) ? 11 : 21;
        chk({tag, "_hazir"}, 128'(bus.hazir), 128'd1);
        bus.anahtar   = key;
        bus.blok      = ct;
        bus.g_gecerli = 1'b1;
        @(posedge clk);
        #1;
        bus.g_gecerli = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (noise) begin
                bus.g_gecerli = 1'($urandom_range(1));
                bus.blok      = rnd128();
                bus.anahtar   = rnd128();
            end
            @(posedge clk);
            lat++;
            #1;
            if (bus.c_gecerli === 1'b1) seen = 1'b1;
        end
        bus.g_gecerli = 1'b0;
        chk({tag, "_pulse_seen"}, 128'(seen), 128'd1);
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_plaintext"}, bus.duz_metin, exp_pt);
        m_cache_key   = key;
        m_cache_valid = (KC != 0);
        done_blocks++;
    endtask

    initial begin
        logic [127:0] key, pt, ct;
        int pulses_before;

        bus.anahtar   = '0;
        bus.blok      = '0;
        bus.g_gecerli = 1'b0;
        rst = 1'b1;

        build_sbox();
        if (ref_encrypt(KEY_C1, PT_C1) !== CT_C1 || ref_encrypt(KEY_B, PT_B) !== CT_B) begin
            $display("FAIL reference_model: encryptor disagrees with FIPS-197 vectors");
            $fatal(1, "reference model broken");
        end

        repeat (3) @(negedge clk);
        chk("reset_hazir", 128'(bus.hazir), 128'd1);
        chk("reset_c_gecerli", 128'(bus.c_gecerli), 128'd0);
        chk("reset_duz_metin", bus.duz_metin, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        do_block("fips_c1", KEY_C1, CT_C1, PT_C1, 1'b0);
        do_block("fips_b", KEY_B, CT_B, PT_B, 1'b0);
        do_block("cache_hit_b2b", KEY_B, CT_B, PT_B, 1'b0);
        do_block("busy_noise", KEY_B, CT_B, PT_B, 1'b1);

        repeat (3) @(negedge clk);
        chk("hold_duz_metin", bus.duz_metin, PT_B);
        chk("pulse_count_directed", 128'(pulses), 128'(done_blocks));

        // Cached key B takes the short path; round 5 is in progress after the fifth edge
        bus.anahtar   = KEY_B;
        bus.blok      = CT_B;
        bus.g_gecerli = 1'b1;
        @(posedge clk);
        #1;
        bus.g_gecerli = 1'b0;
        repeat (5) @(posedge clk);
        pulses_before = pulses;
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_c_gecerli", 128'(bus.c_gecerli), 128'd0);
        chk("midreset_duz_metin", bus.duz_metin, 128'd0);
        chk("midreset_hazir", 128'(bus.hazir), 128'd1);
        m_cache_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midreset_no_pulse", 128'(pulses), 128'(pulses_before));
        @(negedge clk);
        do_block("after_reset_full", KEY_B, CT_B, PT_B, 1'b0);

        key = rnd128();
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(3) != 0) key = rnd128();
            pt = rnd128();
            ct = ref_encrypt(key, pt);
            do_block("loopback", key, ct, pt, 1'($urandom_range(1)));
            if ($urandom_range(7) == 0) @(negedge clk);
        end

        @(negedge clk);
        #1;
        chk("pulse_count_total", 128'(pulses), 128'(done_blocks));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
